// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath widths and the memory-stage control bundle.
package pipeline_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic reg_write;
    logic memto_reg;
    logic mem_write;
    logic mem_read;
  } mem_ctrl_t;

  localparam mem_ctrl_t MEM_CTRL_BUBBLE = '0;

  // A register write only survives if the instruction is real, the conditional
  // move (if any) is taken, and the destination is not the hard-wired zero register.
  function automatic mem_ctrl_t gate_ctrl(
    input logic valid,
    input logic reg_write,
    input logic memto_reg,
    input logic mem_write,
    input logic mem_read,
    input logic cond_mov,
    input logic mov_taken,
    input logic dest_nonzero
  );
    mem_ctrl_t c;
    c.reg_write = valid & reg_write & (~cond_mov | mov_taken) & dest_nonzero;
    c.memto_reg = memto_reg;
    c.mem_write = valid & mem_write;
    c.mem_read  = valid & mem_read;
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/exmem_reg.sv
// EX/MEM pipeline register with stall, flush and conditional-move write gating.
// Optional bubble statistics counter enabled by macro EXMEM_STATS_EN.
module exmem_reg #(
  parameter int DATA_W     = pipeline_pkg::DATA_W,
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  EX_Valid,
  input  logic                  EX_RegWrite,
  input  logic                  EX_MemtoReg,
  input  logic                  EX_MemWrite,
  input  logic                  EX_MemRead,
  input  logic                  EX_CondMov,
  input  logic                  EX_MovTaken,
  input  logic [DATA_W-1:0]     EX_ALUResult,
  input  logic [DATA_W-1:0]     EX_ReadData2,
  input  logic [REG_ADDR_W-1:0] EX_WriteReg,
  output logic                  MEM_Valid,
  output logic                  MEM_RegWrite,
  output logic                  MEM_MemtoReg,
  output logic                  MEM_MemWrite,
  output logic                  MEM_MemRead,
  output logic [DATA_W-1:0]     MEM_ALUResult,
  output logic [DATA_W-1:0]     MEM_ReadData2,
  output logic [REG_ADDR_W-1:0] MEM_WriteReg
`ifdef EXMEM_STATS_EN
  ,
  output logic [31:0]           BubbleCount
`endif
);

  import pipeline_pkg::*;

  logic                  valid_q, valid_d;
  mem_ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0]     alu_q, alu_d;
  logic [DATA_W-1:0]     rd2_q, rd2_d;
  logic [REG_ADDR_W-1:0] wr_q, wr_d;
  logic                  load;

  // Flush overrides stall: a flushed stage always takes a bubble.
  assign load = Flush | ~Stall;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    alu_d   = alu_q;
    rd2_d   = rd2_q;
    wr_d    = wr_q;
    if (load) begin
      alu_d = EX_ALUResult;
      rd2_d = EX_ReadData2;
      wr_d  = EX_WriteReg;
      if (Flush) begin
        valid_d = 1'b0;
        ctrl_d  = MEM_CTRL_BUBBLE;
      end else begin
        valid_d = EX_Valid;
        ctrl_d  = gate_ctrl(EX_Valid, EX_RegWrite, EX_MemtoReg, EX_MemWrite,
                            EX_MemRead, EX_CondMov, EX_MovTaken,
                            (EX_WriteReg != '0));
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= MEM_CTRL_BUBBLE;
      alu_q   <= '0;
      rd2_q   <= '0;
      wr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      alu_q   <= alu_d;
      rd2_q   <= rd2_d;
      wr_q    <= wr_d;
    end
  end

  assign MEM_Valid     = valid_q;
  assign MEM_RegWrite  = ctrl_q.reg_write;
  assign MEM_MemtoReg  = ctrl_q.memto_reg;
  assign MEM_MemWrite  = ctrl_q.mem_write;
  assign MEM_MemRead   = ctrl_q.mem_read;
  assign MEM_ALUResult = alu_q;
  assign MEM_ReadData2 = rd2_q;
  assign MEM_WriteReg  = wr_q;

`ifdef EXMEM_STATS_EN
  logic bubble_inc;

  assign bubble_inc = load & ~valid_d;

  sat_counter #(
    .W (32)
  ) u_bubble_cnt (
    .clk     (Clk),
    .srst    (Reset),
    .inc_i   (bubble_inc),
    .count_o (BubbleCount)
  );
`endif

endmodule

// File: tb/tb_exmem_reg.sv
// Self-checking bench for exmem_reg: directed vector table, hand-written
// stall/flush/reset sequences, and randomized traffic against a reference model.
module tb_exmem_reg;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush;
  logic        EX_Valid, EX_RegWrite, EX_MemtoReg, EX_MemWrite, EX_MemRead;
  logic        EX_CondMov, EX_MovTaken;
  logic [31:0] EX_ALUResult, EX_ReadData2;
  logic [4:0]  EX_WriteReg;
  logic        MEM_Valid, MEM_RegWrite, MEM_MemtoReg, MEM_MemWrite, MEM_MemRead;
  logic [31:0] MEM_ALUResult, MEM_ReadData2;
  logic [4:0]  MEM_WriteReg;
`ifdef EXMEM_STATS_EN
  logic [31:0] BubbleCount;
`endif

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  exmem_reg dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Stall         (Stall),
    .Flush         (Flush),
    .EX_Valid      (EX_Valid),
    .EX_RegWrite   (EX_RegWrite),
    .EX_MemtoReg   (EX_MemtoReg),
    .EX_MemWrite   (EX_MemWrite),
    .EX_MemRead    (EX_MemRead),
    .EX_CondMov    (EX_CondMov),
    .EX_MovTaken   (EX_MovTaken),
    .EX_ALUResult  (EX_ALUResult),
    .EX_ReadData2  (EX_ReadData2),
    .EX_WriteReg   (EX_WriteReg),
    .MEM_Valid     (MEM_Valid),
    .MEM_RegWrite  (MEM_RegWrite),
    .MEM_MemtoReg  (MEM_MemtoReg),
    .MEM_MemWrite  (MEM_MemWrite),
    .MEM_MemRead   (MEM_MemRead),
    .MEM_ALUResult (MEM_ALUResult),
    .MEM_ReadData2 (MEM_ReadData2),
    .MEM_WriteReg  (MEM_WriteReg)
`ifdef EXMEM_STATS_EN
    ,
    .BubbleCount   (BubbleCount)
`endif
  );

  // Reference model: the architectural contents of the MEM stage.
  typedef struct {
    logic        v, rw, m2r, mw, mr;
    logic [31:0] alu, rd2;
    logic [4:0]  wr;
    bit          data_known;
  } stage_t;

  stage_t      m;
  int unsigned m_bub;

  function automatic void model_step();
    if (Reset) begin
      m = '{v:0, rw:0, m2r:0, mw:0, mr:0, alu:0, rd2:0, wr:0, data_known:1};
      m_bub = 0;
    end else if (Flush) begin
      m.v = 0; m.rw = 0; m.m2r = 0; m.mw = 0; m.mr = 0;
      m.data_known = 0;
      if (m_bub != 32'hFFFF_FFFF) m_bub++;
    end else if (!Stall) begin
      m.v   = EX_Valid;
      // write survives only for a real, taken, non-r0 write
      m.rw  = EX_Valid && EX_RegWrite && (!EX_CondMov || EX_MovTaken) && (EX_WriteReg != 0);
      m.m2r = EX_MemtoReg;
      m.mw  = EX_Valid && EX_MemWrite;
      m.mr  = EX_Valid && EX_MemRead;
      m.alu = EX_ALUResult;
      m.rd2 = EX_ReadData2;
      m.wr  = EX_WriteReg;
      m.data_known = 1;
      if (!EX_Valid && m_bub != 32'hFFFF_FFFF) m_bub++;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ex(input logic v, input logic rw, input logic m2r, input logic mw,
                        input logic mr, input logic cm, input logic mt,
                        input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] wr);
    EX_Valid = v; EX_RegWrite = rw; EX_MemtoReg = m2r; EX_MemWrite = mw; EX_MemRead = mr;
    EX_CondMov = cm; EX_MovTaken = mt; EX_ALUResult = alu; EX_ReadData2 = rd2; EX_WriteReg = wr;
  endtask

  task automatic check_bubbles(input string name);
`ifdef EXMEM_STATS_EN
    chk({name, ".bubbles"}, BubbleCount, m_bub);
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  task automatic check_model(input string name);
    $display("txn %s: valid=%0b rw=%0b m2r=%0b mw=%0b mr=%0b alu=%08h wr=%0d",
             name, MEM_Valid, MEM_RegWrite, MEM_MemtoReg, MEM_MemWrite, MEM_MemRead,
             MEM_ALUResult, MEM_WriteReg);
    chk({name, ".valid"}, 32'(MEM_Valid),    32'(m.v));
    chk({name, ".rw"},    32'(MEM_RegWrite), 32'(m.rw));
    chk({name, ".m2r"},   32'(MEM_MemtoReg), 32'(m.m2r));
    chk({name, ".mw"},    32'(MEM_MemWrite), 32'(m.mw));
    chk({name, ".mr"},    32'(MEM_MemRead),  32'(m.mr));
    if (m.data_known) begin
      chk({name, ".alu"}, MEM_ALUResult,     m.alu);
      chk({name, ".rd2"}, MEM_ReadData2,     m.rd2);
      chk({name, ".wr"},  32'(MEM_WriteReg), 32'(m.wr));
    end
    check_bubbles(name);
  endtask

  typedef struct {
    logic        v, rw, m2r, mw, mr, cm, mt;
    logic [31:0] alu, rd2;
    logic [4:0]  wr;
    logic        e_v, e_rw, e_m2r, e_mw, e_mr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // Single-cycle pass-through vectors with hand-derived expectations.
    vecs[0] = '{1,1,0,0,0,0,0, 32'h0000_002A, 32'h0,         5'd8,  1,1,0,0,0};
    vecs[1] = '{1,1,0,0,0,1,0, 32'h0000_0003, 32'h0,         5'd3,  1,0,0,0,0};
    vecs[2] = '{1,1,0,0,0,1,1, 32'h0000_0004, 32'h0,         5'd3,  1,1,0,0,0};
    vecs[3] = '{1,1,0,0,0,0,0, 32'h0000_0005, 32'h0,         5'd0,  1,0,0,0,0};
    vecs[4] = '{0,1,1,1,1,0,0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7,  0,0,1,0,0};
    vecs[5] = '{1,0,1,0,1,0,0, 32'h0000_1000, 32'h0,         5'd9,  1,0,1,0,1};
    vecs[6] = '{1,0,0,1,0,0,0, 32'h0000_2000, 32'hCAFE_F00D, 5'd12, 1,0,0,1,0};
    vecs[7] = '{1,1,1,0,1,1,1, 32'hFFFF_FFFF, 32'h0,         5'd31, 1,1,1,0,1};

    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    set_ex(1, 1, 1, 1, 1, 0, 0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5'd17);
    tick();
    tick();
    chk("reset.valid", 32'(MEM_Valid), 32'd0);
    chk("reset.mr",    32'(MEM_MemRead), 32'd0);
    chk("reset.alu",   MEM_ALUResult, 32'd0);
    chk("reset.rd2",   MEM_ReadData2, 32'd0);
    chk("reset.wr",    32'(MEM_WriteReg), 32'd0);
    check_bubbles("reset");
    Reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      set_ex(vecs[i].v, vecs[i].rw, vecs[i].m2r, vecs[i].mw, vecs[i].mr, vecs[i].cm,
             vecs[i].mt, vecs[i].alu, vecs[i].rd2, vecs[i].wr);
      tick();
      $display("txn vec%0d: valid=%0b rw=%0b alu=%08h wr=%0d", i, MEM_Valid, MEM_RegWrite,
               MEM_ALUResult, MEM_WriteReg);
      chk($sformatf("vec%0d.valid", i), 32'(MEM_Valid),    32'(vecs[i].e_v));
      chk($sformatf("vec%0d.rw", i),    32'(MEM_RegWrite), 32'(vecs[i].e_rw));
      chk($sformatf("vec%0d.m2r", i),   32'(MEM_MemtoReg), 32'(vecs[i].e_m2r));
      chk($sformatf("vec%0d.mw", i),    32'(MEM_MemWrite), 32'(vecs[i].e_mw));
      chk($sformatf("vec%0d.mr", i),    32'(MEM_MemRead),  32'(vecs[i].e_mr));
      chk($sformatf("vec%0d.alu", i),   MEM_ALUResult,     vecs[i].alu);
      chk($sformatf("vec%0d.rd2", i),   MEM_ReadData2,     vecs[i].rd2);
      chk($sformatf("vec%0d.wr", i),    32'(MEM_WriteReg), 32'(vecs[i].wr));
      check_bubbles($sformatf("vec%0d", i));
    end

    // Stall holds the captured instruction while the inputs move on.
    set_ex(1, 1, 0, 0, 0, 0, 0, 32'h11, 32'h0, 5'd4);
    tick();
    chk("stall.load", MEM_ALUResult, 32'h11);
    Stall = 1'b1;
    set_ex(1, 1, 0, 0, 0, 0, 0, 32'h22, 32'h0, 5'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("txn stall%0d: alu=%08h", i, MEM_ALUResult);
      chk($sformatf("stall%0d.alu", i), MEM_ALUResult, 32'h11);
      chk($sformatf("stall%0d.wr", i),  32'(MEM_WriteReg), 32'd4);
    end
    Stall = 1'b0;
    tick();
    chk("unstall.alu", MEM_ALUResult, 32'h22);

    // Flush beats stall and inserts a counted bubble.
    Stall = 1'b1; Flush = 1'b1;
    set_ex(1, 0, 0, 1, 0, 0, 0, 32'h33, 32'h44, 5'd6);
    tick();
    chk("flush.valid", 32'(MEM_Valid),    32'd0);
    chk("flush.mw",    32'(MEM_MemWrite), 32'd0);
    check_model("flush");
    Flush = 1'b0; Stall = 1'b0;

    // Reset during a stall discards the held load.
    set_ex(1, 0, 1, 0, 1, 0, 0, 32'h66, 32'h77, 5'd10);
    tick();
    chk("hold.mr", 32'(MEM_MemRead), 32'd1);
    Stall = 1'b1;
    set_ex(1, 1, 0, 1, 0, 0, 0, 32'h88, 32'h99, 5'd11);
    tick();
    chk("hold.mr2", 32'(MEM_MemRead), 32'd1);
    Reset = 1'b1;
    tick();
    chk("rst_stall.mr",  32'(MEM_MemRead), 32'd0);
    chk("rst_stall.alu", MEM_ALUResult, 32'd0);
    check_model("rst_stall");
    Reset = 1'b0; Stall = 1'b0;
    set_ex(1, 1, 0, 0, 0, 0, 0, 32'h55, 32'h0, 5'd2);
    tick();
    chk("post_rst.alu", MEM_ALUResult, 32'h55);
    chk("post_rst.rw",  32'(MEM_RegWrite), 32'd1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      Reset = ($urandom_range(0, 29) == 0);
      Flush = ($urandom_range(0, 7) == 0);
      Stall = ($urandom_range(0, 3) == 0);
      set_ex(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), $urandom, $urandom,
             ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom));
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
